// File: rtl/reg_pkg.sv
// Shared types and default widths for the reg_skid_buf slice.
package reg_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned CNT_WIDTH_DEF  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } reg_skid_state_e;

endpackage

// File: rtl/reg_rst_y_mode_a_en_y.sv
// Async active-low reset data register with a load enable.
module reg_rst_y_mode_a_en_y #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_d,
  output logic [DATA_WIDTH-1:0] o_q
);

  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q <= '0;
    end else if (i_en) begin
      data_q <= i_d;
    end
  end

  assign o_q = data_q;

endmodule

// File: rtl/reg_skid_buf.sv
// Two-entry valid/ready skid buffer: main register drives o_data, skid absorbs one stall.
// Optional saturating stall counter enabled by REG_SKID_BUF_STALL_CNT_EN.
module reg_skid_buf
  import reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
`ifdef REG_SKID_BUF_STALL_CNT_EN
  , parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready
`ifdef REG_SKID_BUF_STALL_CNT_EN
  , output logic [CNT_WIDTH-1:0] o_stall_cnt
`endif
);

  reg_skid_state_e       state_q, state_d;
  logic                  in_fire, out_fire;
  logic                  main_en, skid_en;
  logic [DATA_WIDTH-1:0] main_d, main_q, skid_q;

  // Handshake flags decoded purely from the state flop.
  assign o_valid  = (state_q != EMPTY);
  assign o_ready  = (state_q != FULL);
  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = i_data;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_en = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          skid_en = 1'b1;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // o_ready is low here, so only the skid word can advance.
        if (out_fire) begin
          main_en = 1'b1;
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  reg_rst_y_mode_a_en_y #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_main_reg (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (main_en),
    .i_d    (main_d),
    .o_q    (main_q)
  );

  reg_rst_y_mode_a_en_y #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid_reg (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (skid_en),
    .i_d    (i_data),
    .o_q    (skid_q)
  );

  assign o_data = main_q;

`ifdef REG_SKID_BUF_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  // Counts edges where the head word is blocked; sticks at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (o_valid && !i_ready && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule
